wb_route_demux: RTL
===================

WB_ROUTE_DEMUX -- requirements
Module: wb_route_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the routed result word.
REQ-002 SHALL have parameter ADDR_W, default 5, width of the destination register index.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream result present.
REQ-006 SHALL have port in_ready  output  1  block accepts upstream result this cycle.
REQ-007 SHALL have port in_sel  input  1  route select: 0 = port A, 1 = port B.
REQ-008 SHALL have port in_addr  input  ADDR_W  destination register index.
REQ-009 SHALL have port in_data  input  DATA_W  result word.
REQ-010 SHALL have ports a_valid / b_valid  output  1  held entry offered to port A / B.
REQ-011 SHALL have ports a_ready / b_ready  input  1  port A / B consumer accepts.
REQ-012 SHALL have ports out_addr  output  ADDR_W  and out_data  output  DATA_W, the held entry, shared by both ports.
REQ-013 SHALL have ports cnt_a, cnt_b, cnt_drop  output  8 each  transfer counters.

Function
REQ-014 SHALL be the 1:2 counterpart of the 2:1 select mux: one input stream routed to exactly one of two consumers, one holding slot.
REQ-015 SHALL implement FSM states IDLE, HOLD_A, HOLD_B; slot holds sel, addr, data.
REQ-016 SHALL drive a_valid = (state==HOLD_A), b_valid = (state==HOLD_B); never both high.
REQ-017 SHALL drive in_ready = (IDLE) or (HOLD_A and a_ready) or (HOLD_B and b_ready); combinational from ready inputs, no input-to-output data path otherwise.
REQ-018 SHALL accept an input when in_valid and in_ready are both high on a rising edge.
REQ-019 SHALL treat an accepted input with in_addr == 0 as a drop: not loaded, no valid raised, cnt_drop incremented.
REQ-020 SHALL on accepted non-drop input load slot and go to HOLD_A (in_sel=0) or HOLD_B (in_sel=1); latency input-accept to valid = 1 cycle.
REQ-021 SHALL in HOLD_x with x_ready high complete transfer, increment cnt_a or cnt_b, and go IDLE unless a new non-drop input is accepted the same cycle, in which case load it and enter its HOLD state (back-to-back, one word per cycle).
REQ-022 SHALL in HOLD_x with x_ready low hold slot, state and out_addr/out_data stable; ready of the non-selected port ignored.
REQ-023 SHALL allow a drop accepted in the same cycle as a completing transfer: both counters update, next state IDLE.
REQ-024 SHALL wrap all counters modulo 256 (255 + 1 = 0), no saturation.
REQ-025 SHALL hold out_addr/out_data at last loaded value in IDLE (value don't-care to consumers).

Reset
REQ-026 SHALL on rst high at a clock edge force state IDLE, a_valid=b_valid=0, out_addr=0, out_data=0, cnt_a=cnt_b=cnt_drop=0.
REQ-027 SHALL take precedence over any same-cycle accept or transfer; a held entry is discarded and not counted.
REQ-028 SHALL drive in_ready low while rst is high; in_ready=1 the first cycle after reset release.

Verification
REQ-029 SHALL cover: reset, then in_valid=1, sel=0, addr=5, data=0xDEADBEEF -> next cycle a_valid=1, b_valid=0, out_addr=5, out_data=0xDEADBEEF; a_ready=1 -> cnt_a=1, IDLE.
REQ-030 SHALL cover: entry for port B held with b_ready=0 for 10 cycles, a_ready=1 -> b_valid stays 1, in_ready=0, data stable, cnt_a unchanged; b_ready=1 -> cnt_b=1.
REQ-031 SHALL cover: continuous in_valid, alternating sel, a_ready=b_ready=1, 20 words -> one transfer per cycle after first, cnt_a=10, cnt_b=10, order preserved.
REQ-032 SHALL cover: input addr=0, data=0x12345678 -> in_ready=1, no valid raised, cnt_drop=1; drop accepted while HOLD_A completes -> cnt_a and cnt_drop both +1, next IDLE.
REQ-033 SHALL cover: 256 transfers to port A -> cnt_a=0 (wrap); 257th -> cnt_a=1.
REQ-034 SHALL cover: rst asserted while HOLD_B with b_ready=1 and in_valid=1 -> next cycle all outputs at reset values, no count.

Source files
------------

// File: rtl/wb_route_demux_if.sv
// Handshake bundle for wb_route_demux: one upstream result stream in, two
// consumer ports (A/B) out sharing a single address/data bus, plus the
// transfer counters.
//   slave  modport : the demux side (drives in_ready, *_valid, out_*, cnt_*)
//   master modport : the producer/consumer side (drives in_*, *_ready)
interface wb_route_demux_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sel;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              a_valid;
  logic              b_valid;
  logic              a_ready;
  logic              b_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic [7:0]        cnt_a;
  logic [7:0]        cnt_b;
  logic [7:0]        cnt_drop;

  modport slave (
    input  in_valid, in_sel, in_addr, in_data, a_ready, b_ready,
    output in_ready, a_valid, b_valid, out_addr, out_data,
    output cnt_a, cnt_b, cnt_drop
  );

  modport master (
    output in_valid, in_sel, in_addr, in_data, a_ready, b_ready,
    input  in_ready, a_valid, b_valid, out_addr, out_data,
    input  cnt_a, cnt_b, cnt_drop
  );
endinterface

// File: rtl/wb_route_demux.sv
// wb_route_demux: 1:2 result router with a single holding slot.
// An accepted upstream word is held and offered to port A (in_sel=0) or
// port B (in_sel=1) until that port accepts. Words addressed to register 0
// are accepted and counted as drops but never offered downstream.
//   clk      : single clock, rising edge
//   rst      : synchronous active-high reset
//   bus      : wb_route_demux_if.slave (in_* stream, a_/b_ handshakes,
//              shared out_addr/out_data, cnt_a/cnt_b/cnt_drop counters)
module wb_route_demux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic             clk,
  input logic             rst,
  wb_route_demux_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_A = 2'd1,
    HOLD_B = 2'd2
  } state_t;

  state_t            state_q;
  logic              a_valid_q;
  logic              b_valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [7:0]        cnt_a_q;
  logic [7:0]        cnt_b_q;
  logic [7:0]        cnt_drop_q;

  logic              done_a;
  logic              done_b;
  logic              in_ready_w;
  logic              accept;
  logic              drop;
  logic              load;
  logic [7:0]        cnt_a_d;
  logic [7:0]        cnt_b_d;
  logic [7:0]        cnt_drop_d;

  // Only the ready of the port currently holding the entry matters.
  assign done_a = (state_q == HOLD_A) && bus.a_ready;
  assign done_b = (state_q == HOLD_B) && bus.b_ready;

  // The slot frees up in the same cycle it drains, so a new word can be
  // taken back-to-back. Held low during reset so nothing is accepted then.
  assign in_ready_w = !rst && ((state_q == IDLE) || done_a || done_b);

  assign accept = bus.in_valid && in_ready_w;
  assign drop   = accept && (bus.in_addr == '0);
  assign load   = accept && (bus.in_addr != '0);

  // Counters wrap naturally at 8 bits.
  assign cnt_a_d    = done_a ? cnt_a_q + 8'd1 : cnt_a_q;
  assign cnt_b_d    = done_b ? cnt_b_q + 8'd1 : cnt_b_q;
  assign cnt_drop_d = drop ? cnt_drop_q + 8'd1 : cnt_drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_a_q    <= 8'd0;
      cnt_b_q    <= 8'd0;
      cnt_drop_q <= 8'd0;
    end else begin
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      cnt_drop_q <= cnt_drop_d;
      if (load) begin
        // A load can only happen from IDLE or a draining HOLD, so the
        // previous entry is never overwritten before it is consumed.
        addr_q    <= bus.in_addr;
        data_q    <= bus.in_data;
        state_q   <= bus.in_sel ? HOLD_B : HOLD_A;
        a_valid_q <= !bus.in_sel;
        b_valid_q <= bus.in_sel;
      end else if (done_a || done_b) begin
        // addr_q/data_q intentionally keep their last value.
        state_q   <= IDLE;
        a_valid_q <= 1'b0;
        b_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready = in_ready_w;
  assign bus.a_valid  = a_valid_q;
  assign bus.b_valid  = b_valid_q;
  assign bus.out_addr = addr_q;
  assign bus.out_data = data_q;
  assign bus.cnt_a    = cnt_a_q;
  assign bus.cnt_b    = cnt_b_q;
  assign bus.cnt_drop = cnt_drop_q;

endmodule
